reg_wb_arbiter: RTL and testbench
=================================

# reg_wb_arbiter

Write-back arbiter for the register file's single write port. It accepts two requesters over valid/ready handshakes: port A is the single-cycle ALU result and port B is the long-latency load/multiply result. It grants one request per cycle and drives a registered write command into the register file's WE3/AD3/WD3. Port A has fixed priority, and a starvation counter forces a grant to port B after a bounded wait.

## Interface
Parameters:
- ADDRESS_WIDTH, 5, register address width
- DATA_WIDTH, 32, write data width
- STARVE_LIMIT, 4, consecutive cycles B may wait (valid && !ready) before a forced grant; legal range 1..255

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  ALU write request
- a_addr  in  ADDRESS_WIDTH  ALU destination register
- a_data  in  DATA_WIDTH  ALU result
- a_ready  out  1  ALU request accepted this cycle
- b_valid  in  1  load/mul write request
- b_addr  in  ADDRESS_WIDTH  load/mul destination register
- b_data  in  DATA_WIDTH  load/mul result
- b_ready  out  1  load/mul request accepted this cycle
- wb_we  out  1  to register file WE3
- wb_addr  out  ADDRESS_WIDTH  to register file AD3
- wb_data  out  DATA_WIDTH  to register file WD3
- force_b  out  1  high while the arbiter is in FORCE_B (debug)

## Operation
- Handshake: a transfer occurs when valid && ready at posedge. Valid, addr and data must stay stable until ready. Ready is combinational from state and the valids, and never depends on itself.
- States: NORMAL, FORCE_B.
- NORMAL:
  - a_ready = 1 and b_ready = !a_valid.
  - A wins any simultaneous request.
- FORCE_B:
  - a_ready = 0 and b_ready = 1.
  - Transition to NORMAL after the B handshake.
  - If b_valid is low in FORCE_B, return to NORMAL next cycle and clear wait_cnt. This is a protocol violation, but it must not hang the arbiter.
- wait_cnt:
  - Increments each cycle b_valid && !b_ready in NORMAL, saturating at STARVE_LIMIT.
  - Clears on any B handshake.
  - When wait_cnt == STARVE_LIMIT at posedge, the state becomes FORCE_B. The increment that reaches the limit and the transition happen on consecutive edges, so B waits at most STARVE_LIMIT+1 cycles.
- Width: wait_cnt is $clog2(STARVE_LIMIT+1) bits.
- x0: a handshake with addr == 0 is accepted (ready honored) but produces wb_we = 0. The arbiter never issues a write to x0.
- Reset (asynchronous, rst high):
  - state = NORMAL, wait_cnt = 0.
  - wb_we = 0, wb_addr = 0, wb_data = 0, force_b = 0.
  - a_ready and b_ready follow NORMAL rules once rst deasserts; while rst is high both are 0.
  - Reset mid-FORCE_B drops the pending force. Any request accepted on the last edge before reset is lost, and its producer must re-issue.

## Timing
- Latency: handshake at edge N gives wb_we/wb_addr/wb_data valid from edge N to edge N+1. The register file writes on the following negedge, within the same cycle.
- Throughput: one write per cycle. wb_we is high for exactly one cycle per non-x0 handshake.
- wb_addr/wb_data hold their last value when wb_we = 0.
- force_b is registered and equals (state == FORCE_B).
- No combinational path from inputs to wb_* outputs.

## Configuration
- REG_WB_ARB_STATS_EN:
  - Defined: adds outputs stat_a_grants, stat_b_grants and stat_b_stall, each 32 bits.
  - These count A handshakes, B handshakes, and cycles with b_valid && !b_ready.
  - Counters wrap at 2^32 and reset to 0 on rst.
- Undefined: the ports and logic are absent, and arbitration behaviour is identical.

## Structure
- Package reg_wb_arb_pkg:
  - arb_state_t enum {NORMAL, FORCE_B}
  - localparam ZERO_REG = '0
  - typedef wb_cmd_t struct {we, addr, data} for the registered output.
- Sub-module reg_wb_arb_stats: the three counters, instantiated only under REG_WB_ARB_STATS_EN.
- Arbitration, state machine and output register stay in the top module.

## Test plan
- Reset: assert rst mid-simulation with both valids high -> wb_we=0, wb_addr=0, wb_data=0, force_b=0, a_ready=b_ready=0 immediately, without waiting for a clock edge.
- Solo A: a_valid=1, a_addr=10, a_data=0x0000_002A for one cycle -> next cycle wb_we=1, wb_addr=10, wb_data=0x2A; cycle after that wb_we=0.
- Priority: a_valid and b_valid both high, B addr=11 data=7 -> a_ready=1, b_ready=0; A written first.
- Starvation (STARVE_LIMIT=4): a_valid held high, b_valid high from cycle 0 -> b_ready=0 for cycles 0-4, force_b=1 and b_ready=1 in cycle 5, a_ready=0 that cycle; back to NORMAL in cycle 6 with wait_cnt=0.
- x0 drop: b_valid=1, b_addr=0, b_data=0xFFFF_FFFF -> b_ready=1, wb_we stays 0; with stats enabled, stat_b_grants increments by 1.
- Protocol violation: reach FORCE_B, then deassert b_valid -> NORMAL the next cycle, wait_cnt=0, a_ready=1.

Source files
------------

// File: rtl/reg_wb_arb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package reg_wb_arb_pkg;

    typedef enum logic {
        NORMAL  = 1'b0,
        FORCE_B = 1'b1
    } arb_state_t;

    // Architectural zero register; writes to it are swallowed.
    localparam logic [31:0] ZERO_REG = '0;

    // Default-width view of the registered write command.
    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_DATA_W = 32;

    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_cmd_t;

endpackage

// File: rtl/reg_wb_arb_stats.sv
// Grant and stall counters for the write-back arbiter (REG_WB_ARB_STATS_EN builds only).
module reg_wb_arb_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_a_hs,
    input  logic        i_b_hs,
    input  logic        i_b_stall,
    output logic [31:0] o_a_grants,
    output logic [31:0] o_b_grants,
    output logic [31:0] o_b_stall
);

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_a_grants <= '0;
            o_b_grants <= '0;
            o_b_stall  <= '0;
        end else begin
            if (i_a_hs)    o_a_grants <= o_a_grants + 32'd1;
            if (i_b_hs)    o_b_grants <= o_b_grants + 32'd1;
            if (i_b_stall) o_b_stall  <= o_b_stall + 32'd1;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter: A (ALU) has fixed priority, B (load/mul) is forced through
// after a bounded wait. Optional counters under REG_WB_ARB_STATS_EN.
module reg_wb_arbiter
    import reg_wb_arb_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    input  logic [ADDRESS_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0]    a_data,
    output logic                     a_ready,
    input  logic                     b_valid,
    input  logic [ADDRESS_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0]    b_data,
    output logic                     b_ready,
    output logic                     wb_we,
    output logic [ADDRESS_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     force_b
`ifdef REG_WB_ARB_STATS_EN
    ,
    output logic [31:0]              stat_a_grants,
    output logic [31:0]              stat_b_grants,
    output logic [31:0]              stat_b_stall
`endif
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic                     we;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
    } cmd_t;

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_nxt;
    cmd_t             r_wb;
    cmd_t             w_wb_nxt;
    logic             w_a_hs;
    logic             w_b_hs;
    logic             w_b_stall;
    logic             w_at_limit;

    // Ready generation: A always wins in NORMAL, B owns the port in FORCE_B.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            if (r_state == NORMAL) begin
                a_ready = 1'b1;
                b_ready = !a_valid;
            end else begin
                b_ready = 1'b1;
            end
        end
    end

    assign w_a_hs     = a_valid && a_ready;
    assign w_b_hs     = b_valid && b_ready;
    assign w_b_stall  = b_valid && !b_ready;
    assign w_at_limit = (r_wait_cnt == CNT_W'(STARVE_LIMIT));

    // Next state and starvation counter.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            NORMAL: begin
                // A B grant that lands on the limit cycle already served B,
                // so it cancels the pending force instead of triggering it.
                if (w_b_hs) begin
                    w_wait_nxt = '0;
                end else if (w_at_limit) begin
                    w_state_nxt = FORCE_B;
                end else if (w_b_stall) begin
                    w_wait_nxt = r_wait_cnt + CNT_W'(1);
                end
            end
            FORCE_B: begin
                // Leave after one cycle whether or not B actually transferred.
                w_state_nxt = NORMAL;
                w_wait_nxt  = '0;
            end
            default: begin
                w_state_nxt = NORMAL;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // Next write command; x0 handshakes are accepted but never written.
    always_comb begin
        w_wb_nxt    = r_wb;
        w_wb_nxt.we = 1'b0;
        if (w_a_hs) begin
            if (a_addr != ADDRESS_WIDTH'(ZERO_REG)) begin
                w_wb_nxt.we   = 1'b1;
                w_wb_nxt.addr = a_addr;
                w_wb_nxt.data = a_data;
            end
        end else if (w_b_hs) begin
            if (b_addr != ADDRESS_WIDTH'(ZERO_REG)) begin
                w_wb_nxt.we   = 1'b1;
                w_wb_nxt.addr = b_addr;
                w_wb_nxt.data = b_data;
            end
        end
    end

    // State, counter and output command registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= NORMAL;
            r_wait_cnt <= '0;
            r_wb       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_wb       <= w_wb_nxt;
        end
    end

    assign wb_we   = r_wb.we;
    assign wb_addr = r_wb.addr;
    assign wb_data = r_wb.data;
    assign force_b = (r_state == FORCE_B);

`ifdef REG_WB_ARB_STATS_EN
    reg_wb_arb_stats u_stats (
        .clk        (clk),
        .rst        (rst),
        .i_a_hs     (w_a_hs),
        .i_b_hs     (w_b_hs),
        .i_b_stall  (w_b_stall),
        .o_a_grants (stat_a_grants),
        .o_b_grants (stat_b_grants),
        .o_b_stall  (stat_b_stall)
    );
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter (default build, REG_WB_ARB_STATS_EN undefined).
module tb_reg_wb_arbiter;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, b_valid;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready;
    logic          wb_we, force_b;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    reg_wb_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .STARVE_LIMIT  (LIMIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .b_ready (b_ready),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .force_b (force_b)
    );

    // Reference model: B is owed the port once it has been refused LIMIT+1 times in a row.
    int            m_stalls;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    function automatic bit m_forced();
        return m_stalls > int'(LIMIT);
    endfunction

    function automatic bit m_a_rdy();
        return !rst && !m_forced();
    endfunction

    function automatic bit m_b_rdy();
        return !rst && (m_forced() || !a_valid);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_stalls <= 0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_data   <= '0;
        end else begin
            if (a_valid && m_a_rdy()) begin
                m_we <= (a_addr != '0);
                if (a_addr != '0) begin
                    m_addr <= a_addr;
                    m_data <= a_data;
                end
            end else if (b_valid && m_b_rdy()) begin
                m_we <= (b_addr != '0);
                if (b_addr != '0) begin
                    m_addr <= b_addr;
                    m_data <= b_data;
                end
            end else begin
                m_we <= 1'b0;
            end
            if (m_forced() || (b_valid && m_b_rdy()))
                m_stalls <= 0;
            else if (b_valid)
                m_stalls <= m_stalls + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_a_ready", 64'(a_ready), 64'(m_a_rdy()));
            check("m_b_ready", 64'(b_ready), 64'(m_b_rdy()));
            check("m_force_b", 64'(force_b), 64'(m_forced()));
            check("m_wb_we",   64'(wb_we),   64'(m_we));
            check("m_wb_addr", 64'(wb_addr), 64'(m_addr));
            check("m_wb_data", 64'(wb_data), 64'(m_data));
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ha, hb;
        rst = 1'b1;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_wb_we",   64'(wb_we),   64'd0);
        check("rst_wb_addr", 64'(wb_addr), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        check("rst_force_b", 64'(force_b), 64'd0);
        check("rst_a_ready", 64'(a_ready), 64'd0);
        check("rst_b_ready", 64'(b_ready), 64'd0);
        nxt();
        rst = 1'b0;

        // Solo A
        a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h0000_002A;
        @(negedge clk);
        check("soloA_a_ready", 64'(a_ready), 64'd1);
        nxt();
        a_valid = 1'b0;
        @(negedge clk);
        check("soloA_wb_we",   64'(wb_we),   64'd1);
        check("soloA_wb_addr", 64'(wb_addr), 64'd10);
        check("soloA_wb_data", 64'(wb_data), 64'h2A);
        nxt();
        @(negedge clk);
        check("soloA_we_low", 64'(wb_we),   64'd0);
        check("soloA_hold",   64'(wb_addr), 64'd10);

        // Priority
        nxt();
        a_valid = 1'b1; a_addr = 5'd5;  a_data = 32'h55;
        b_valid = 1'b1; b_addr = 5'd11; b_data = 32'd7;
        @(negedge clk);
        check("prio_a_ready", 64'(a_ready), 64'd1);
        check("prio_b_ready", 64'(b_ready), 64'd0);
        nxt();
        a_valid = 1'b0;
        @(negedge clk);
        check("prio_A_addr", 64'(wb_addr), 64'd5);
        check("prio_A_data", 64'(wb_data), 64'h55);
        check("prio_b_rdy2", 64'(b_ready), 64'd1);
        nxt();
        b_valid = 1'b0;
        @(negedge clk);
        check("prio_B_we",   64'(wb_we),   64'd1);
        check("prio_B_addr", 64'(wb_addr), 64'd11);
        check("prio_B_data", 64'(wb_data), 64'd7);

        // Starvation with a_valid held
        nxt();
        a_valid = 1'b1; a_addr = 5'd1;  a_data = 32'h100;
        b_valid = 1'b1; b_addr = 5'd12; b_data = 32'h99;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("starve_b_wait", 64'(b_ready), 64'd0);
            nxt();
        end
        @(negedge clk);
        check("starve_force_b", 64'(force_b), 64'd1);
        check("starve_b_ready", 64'(b_ready), 64'd1);
        check("starve_a_ready", 64'(a_ready), 64'd0);
        nxt();
        b_valid = 1'b0;
        @(negedge clk);
        check("starve_back_normal", 64'(force_b), 64'd0);
        check("starve_a_back",      64'(a_ready), 64'd1);
        check("starve_B_addr",      64'(wb_addr), 64'd12);
        check("starve_B_data",      64'(wb_data), 64'h99);

        // Protocol violation: drop b_valid inside FORCE_B
        nxt();
        b_valid = 1'b1; b_addr = 5'd13; b_data = 32'h1313;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            nxt();
        end
        b_valid = 1'b0;
        @(negedge clk);
        check("viol_force_b", 64'(force_b), 64'd1);
        check("viol_a_ready", 64'(a_ready), 64'd0);
        nxt();
        @(negedge clk);
        check("viol_normal",  64'(force_b), 64'd0);
        check("viol_a_rdy",   64'(a_ready), 64'd1);
        check("viol_no_we",   64'(wb_we),   64'd0);
        nxt();
        b_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("viol_wait_cleared", 64'(b_ready), 64'd0);
            nxt();
        end
        @(negedge clk);
        check("viol_reforce", 64'(force_b), 64'd1);
        nxt();
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        check("viol_B_addr", 64'(wb_addr), 64'd13);
        check("viol_B_data", 64'(wb_data), 64'h1313);

        // x0 drop
        nxt();
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFF_FFFF;
        @(negedge clk);
        check("x0_b_ready", 64'(b_ready), 64'd1);
        nxt();
        b_valid = 1'b0;
        @(negedge clk);
        check("x0_no_we",     64'(wb_we),   64'd0);
        check("x0_hold_addr", 64'(wb_addr), 64'd13);
        check("x0_hold_data", 64'(wb_data), 64'h1313);

        // Mid-simulation reset with both valids high
        nxt();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'd3;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'd4;
        nxt();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("mrst_wb_we",   64'(wb_we),   64'd0);
        check("mrst_wb_addr", 64'(wb_addr), 64'd0);
        check("mrst_wb_data", 64'(wb_data), 64'd0);
        check("mrst_force_b", 64'(force_b), 64'd0);
        check("mrst_a_ready", 64'(a_ready), 64'd0);
        check("mrst_b_ready", 64'(b_ready), 64'd0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        check("mrst_a_after", 64'(a_ready), 64'd1);
        check("mrst_b_after", 64'(b_ready), 64'd0);
        nxt();
        a_valid = 1'b0;
        @(negedge clk);
        check("mrst_b_served", 64'(b_ready), 64'd1);
        nxt();
        b_valid = 1'b0;

        // Randomized traffic; each producer holds its request until accepted
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            ha = a_valid && m_a_rdy();
            hb = b_valid && m_b_rdy();
            nxt();
            rst = 1'b0;
            if (!a_valid || ha) begin
                if ($urandom_range(0, 9) < 6) begin
                    a_valid = 1'b1;
                    a_addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                    a_data  = $urandom;
                end else begin
                    a_valid = 1'b0;
                end
            end
            if (!b_valid || hb) begin
                if ($urandom_range(0, 9) < 5) begin
                    b_valid = 1'b1;
                    b_addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                    b_data  = $urandom;
                end else begin
                    b_valid = 1'b0;
                end
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
